// File: rtl/byte_pair_pkg.sv
// Shared types and defaults for the byte_pair_loader feeder.
package byte_pair_pkg;

    localparam int DEFAULT_N       = 16;
    localparam int DEFAULT_TIMEOUT = 15;
    localparam int DEFAULT_CW      = 8;

    typedef enum logic [1:0] {
        HI_ONLY = 2'd0,
        LO_ONLY = 2'd1,
        BOTH    = 2'd2,
        RSVD    = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HAVE_HI  = 3'd1,
        S_COMMIT_H = 3'd2,
        S_COMMIT_L = 3'd3,
        S_COMMIT_B = 3'd4
    } state_t;

    function automatic logic is_commit(input state_t st);
        logic r;
        case (st)
            S_COMMIT_H, S_COMMIT_L, S_COMMIT_B: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bp_timeout_timer.sv
// Idle-cycle watchdog for a half-assembled word; expire is high in the
// cycle where the count sits at TIMEOUT-1 and another idle cycle is seen.
module bp_timeout_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic clear_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // next-count selection
    always_comb begin
        timer_d = timer_q;
        if (clr) begin
            timer_d = {TW{1'b0}};
        end else if (en) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    assign expire = en && !clr && (timer_q == TW'(TIMEOUT - 1));

    // count register
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            timer_q <= {TW{1'b0}};
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/byte_pair_loader.sv
// Byte-stream feeder for a split high/low load register.
// Optional macro BYTE_PAIR_PARTIAL_COMMIT_EN: on watchdog expiry, commit the held high byte alone.
module byte_pair_loader
    import byte_pair_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CW      = DEFAULT_CW
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic [N/2-1:0]  in_data,
    input  logic [1:0]      in_mode,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N/2-1:0]  inh,
    output logic [N/2-1:0]  inl,
    output logic            loadh,
    output logic            loadl,
    output logic            done,
    output logic            timeout_err,
    output logic [CW-1:0]   word_count
);

    localparam int H = N / 2;

    state_t          state_q, state_d;
    logic [H-1:0]    hi_buf_q, hi_buf_d;
    logic [H-1:0]    inh_q, inh_d;
    logic [H-1:0]    inl_q, inl_d;
    logic            loadh_q, loadh_d;
    logic            loadl_q, loadl_d;
    logic            done_q, done_d;
    logic            terr_q, terr_d;
    logic [CW-1:0]   wc_q, wc_d;

    logic            xfer_s;
    logic            tmr_clr_s;
    logic            tmr_en_s;
    logic            expire_s;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_HAVE_HI);
    assign xfer_s    = in_valid && in_ready;
    assign tmr_clr_s = (state_q != S_HAVE_HI);
    assign tmr_en_s  = (state_q == S_HAVE_HI) && !xfer_s;

    bp_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .clear_n (clear_n),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .expire  (expire_s)
    );

    // next-state, byte capture and pulse decode
    always_comb begin
        state_d  = state_q;
        hi_buf_d = hi_buf_q;
        inh_d    = inh_q;
        inl_d    = inl_q;
        terr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer_s) begin
                    case (mode_t'(in_mode))
                        HI_ONLY: begin
                            inh_d   = in_data;
                            state_d = S_COMMIT_H;
                        end
                        LO_ONLY: begin
                            inl_d   = in_data;
                            state_d = S_COMMIT_L;
                        end
                        BOTH: begin
                            hi_buf_d = in_data;
                            state_d  = S_HAVE_HI;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HAVE_HI: begin
                if (xfer_s) begin
                    inh_d   = hi_buf_q;
                    inl_d   = in_data;
                    state_d = S_COMMIT_B;
                end else if (expire_s) begin
                    terr_d   = 1'b1;
                    hi_buf_d = {H{1'b0}};
`ifdef BYTE_PAIR_PARTIAL_COMMIT_EN
                    inh_d    = hi_buf_q;
                    state_d  = S_COMMIT_H;
`else
                    state_d  = S_IDLE;
`endif
                end else begin
                    state_d = S_HAVE_HI;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // pulses are registered so they line up with the COMMIT_* cycle
        loadh_d = (state_d == S_COMMIT_H) || (state_d == S_COMMIT_B);
        loadl_d = (state_d == S_COMMIT_L) || (state_d == S_COMMIT_B);
        done_d  = is_commit(state_d);
        if (done_d) begin
            wc_d = wc_q + CW'(1);
        end else begin
            wc_d = wc_q;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= S_IDLE;
            hi_buf_q <= {H{1'b0}};
            inh_q    <= {H{1'b0}};
            inl_q    <= {H{1'b0}};
            loadh_q  <= 1'b0;
            loadl_q  <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
            wc_q     <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            hi_buf_q <= hi_buf_d;
            inh_q    <= inh_d;
            inl_q    <= inl_d;
            loadh_q  <= loadh_d;
            loadl_q  <= loadl_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
            wc_q     <= wc_d;
        end
    end

    assign inh         = inh_q;
    assign inl         = inl_q;
    assign loadh       = loadh_q;
    assign loadl       = loadl_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign word_count  = wc_q;

endmodule

// File: tb/tb_byte_pair_loader.sv
// Directed self-checking bench for byte_pair_loader (N=16, TIMEOUT=4, CW=2).
module tb_byte_pair_loader;

    logic       clk;
    logic       clear_n;
    logic [7:0] in_data;
    logic [1:0] in_mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] inh;
    logic [7:0] inl;
    logic       loadh;
    logic       loadl;
    logic       done;
    logic       timeout_err;
    logic [1:0] word_count;

    int errors;
    int checks;
    int exp_wc;

    byte_pair_loader #(
        .N       (16),
        .TIMEOUT (4),
        .CW      (2)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .in_data     (in_data),
        .in_mode     (in_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inh         (inh),
        .inl         (inl),
        .loadh       (loadh),
        .loadl       (loadl),
        .done        (done),
        .timeout_err (timeout_err),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m);
        in_valid = v;
        in_data  = d;
        in_mode  = m;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_loadh"}, 32'(loadh), 32'd0);
        chk({tag, "_loadl"}, 32'(loadl), 32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_terr"},  32'(timeout_err), 32'd0);
        chk({tag, "_wc"},    32'(word_count), 32'(exp_wc % 4));
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        exp_wc  = 0;
        clear_n = 1'b0;
        drive(1'b0, 8'h00, 2'd0);
        tick();
        chk_quiet("rst");
        chk("rst_inh", 32'(inh), 32'h0);
        chk("rst_inl", 32'(inl), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        clear_n = 1'b1;
        tick();

        // reset while a BOTH word is half assembled
        drive(1'b1, 8'hAB, 2'd2);
        tick();
        drive(1'b0, 8'h00, 2'd0);
        chk("hh_ready", 32'(in_ready), 32'd1);
        clear_n = 1'b0;
        #1;
        chk_quiet("arst");
        tick();
        clear_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_quiet("post_rst");
            chk("post_rst_inh", 32'(inh), 32'h0);
        end

        // HI_ONLY
        drive(1'b1, 8'h5A, 2'd0);
        tick();
        drive(1'b0, 8'h00, 2'd0);
        exp_wc = exp_wc + 1;
        chk("hi_loadh", 32'(loadh), 32'd1);
        chk("hi_loadl", 32'(loadl), 32'd0);
        chk("hi_inh",   32'(inh),   32'h5A);
        chk("hi_done",  32'(done),  32'd1);
        chk("hi_wc",    32'(word_count), 32'd1);
        chk("hi_ready", 32'(in_ready), 32'd0);
        tick();
        chk_quiet("hi_after");
        chk("hi_after_ready", 32'(in_ready), 32'd1);
        chk("hi_after_inh", 32'(inh), 32'h5A);

        // BOTH; second byte carries a mode that must be ignored
        drive(1'b1, 8'h12, 2'd2);
        tick();
        chk_quiet("b_mid");
        chk("b_mid_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 8'h34, 2'd0);
        tick();
        drive(1'b0, 8'h00, 2'd0);
        exp_wc = exp_wc + 1;
        chk("b_loadh", 32'(loadh), 32'd1);
        chk("b_loadl", 32'(loadl), 32'd1);
        chk("b_word",  32'({inh, inl}), 32'h1234);
        chk("b_done",  32'(done), 32'd1);
        chk("b_wc",    32'(word_count), 32'd2);
        tick();
        chk_quiet("b_after");

        // back-to-back LO_ONLY, valid held; bytes on the bus during commit are ignored
        drive(1'b1, 8'h01, 2'd1);
        tick();
        exp_wc = exp_wc + 1;
        chk("lo1_loadl", 32'(loadl), 32'd1);
        chk("lo1_loadh", 32'(loadh), 32'd0);
        chk("lo1_inl",   32'(inl), 32'h01);
        chk("lo1_inh",   32'(inh), 32'h12);
        chk("lo1_wc",    32'(word_count), 32'd3);
        drive(1'b1, 8'hEE, 2'd1);
        tick();
        chk("lo1_gap", 32'(loadl), 32'd0);
        drive(1'b1, 8'h02, 2'd1);
        tick();
        exp_wc = exp_wc + 1;
        chk("lo2_loadl", 32'(loadl), 32'd1);
        chk("lo2_inl",   32'(inl), 32'h02);
        chk("lo2_wrap",  32'(word_count), 32'd0);
        drive(1'b1, 8'hEE, 2'd1);
        tick();
        chk("lo2_gap", 32'(loadl), 32'd0);
        drive(1'b1, 8'h03, 2'd1);
        tick();
        drive(1'b0, 8'h00, 2'd0);
        exp_wc = exp_wc + 1;
        chk("lo3_loadl", 32'(loadl), 32'd1);
        chk("lo3_inl",   32'(inl), 32'h03);
        chk("lo3_wc",    32'(word_count), 32'd1);
        tick();
        chk_quiet("lo_after");

        // watchdog: four idle cycles in HAVE_HI
        drive(1'b1, 8'hCC, 2'd2);
        tick();
        drive(1'b0, 8'h00, 2'd0);
        for (int i = 0; i < 4; i++) begin
            chk_quiet("to_wait");
            tick();
        end
        chk("to_terr", 32'(timeout_err), 32'd1);
`ifdef BYTE_PAIR_PARTIAL_COMMIT_EN
        exp_wc = exp_wc + 1;
        chk("to_loadh", 32'(loadh), 32'd1);
        chk("to_inh",   32'(inh), 32'hCC);
        chk("to_done",  32'(done), 32'd1);
        chk("to_ready", 32'(in_ready), 32'd0);
`else
        chk("to_loadh", 32'(loadh), 32'd0);
        chk("to_inh",   32'(inh), 32'h12);
        chk("to_done",  32'(done), 32'd0);
        chk("to_ready", 32'(in_ready), 32'd1);
`endif
        chk("to_loadl", 32'(loadl), 32'd0);
        chk("to_wc",    32'(word_count), 32'(exp_wc % 4));
        tick();
        chk_quiet("to_after");

        // second byte arriving in the expiry cycle wins over the watchdog
        drive(1'b1, 8'hDD, 2'd2);
        tick();
        drive(1'b0, 8'h00, 2'd0);
        tick();
        tick();
        tick();
        drive(1'b1, 8'hEE, 2'd3);
        tick();
        drive(1'b0, 8'h00, 2'd0);
        exp_wc = exp_wc + 1;
        chk("race_terr", 32'(timeout_err), 32'd0);
        chk("race_both", 32'({loadh, loadl}), 32'd3);
        chk("race_word", 32'({inh, inl}), 32'hDDEE);
        chk("race_wc",   32'(word_count), 32'(exp_wc % 4));
        tick();
        chk_quiet("race_after");

        // reserved mode: byte consumed, nothing committed
        drive(1'b1, 8'h77, 2'd3);
        chk("rsvd_ready_in", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 8'h00, 2'd0);
        chk_quiet("rsvd");
        chk("rsvd_ready", 32'(in_ready), 32'd1);
        tick();
        chk_quiet("rsvd_after");
        chk("rsvd_inl", 32'(inl), 32'hEE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/byte_pair_loader.md
Name: byte_pair_loader

Overview:
- Upstream feeder for the split high/low load register, with N=16 by default.
- Accepts a byte stream over a valid/ready handshake.
- Assembles the bytes into high-only, low-only or full-word writes.
- Drives the register's inh/inl/loadh/loadl inputs as one-cycle registered load pulses.
- Includes a watchdog that aborts a half-assembled word, plus a transaction counter.

Parameters:
- N, 16: width of the target register. Must be even; H = N/2 is the byte width.
- TIMEOUT, 15: idle cycles allowed in HAVE_HI before the pending word is abandoned. Must be ≥1.
- CW, 8: width of word_count.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- in_data  in  H  byte from the producer.
- in_mode  in  2  transaction type, sampled only with the first byte of a transaction: 0=HI_ONLY, 1=LO_ONLY, 2=BOTH (high byte first), 3=reserved.
- in_valid  in  1  producer has a byte.
- in_ready  out  1  loader can accept a byte. A transfer happens when in_valid && in_ready.
- inh  out  H  high byte to the register.
- inl  out  H  low byte to the register.
- loadh  out  1  one-cycle load-high pulse.
- loadl  out  1  one-cycle load-low pulse.
- done  out  1  one-cycle pulse, coincident with the load pulses of every committed transaction.
- timeout_err  out  1  one-cycle pulse when a pending BOTH word is abandoned.
- word_count  out  CW  count of committed transactions.

Behaviour:
- Reset (clear_n=0, asynchronous): the following are all forced to 0 immediately:
  - state=IDLE
  - inh, inl, loadh, loadl, done, timeout_err
  - word_count, timer
- Reset mid-transaction discards any held byte. No load pulse is emitted.
- All outputs are registered. Sole exception: in_ready is decoded combinationally from state.
- States:
  - IDLE: in_ready=1. On transfer:
    - mode HI_ONLY: inh<=in_data, go to COMMIT_H.
    - mode LO_ONLY: inl<=in_data, go to COMMIT_L.
    - mode BOTH: hold in_data in hi_buf, clear timer, go to HAVE_HI.
    - mode 3: byte is consumed and dropped, state stays IDLE, no pulse.
  - HAVE_HI: in_ready=1.
    - On transfer: inh<=hi_buf, inl<=in_data, go to COMMIT_B. in_mode is ignored.
    - Without transfer: timer increments.
    - When timer reaches TIMEOUT-1 with no transfer: pulse timeout_err next cycle, discard hi_buf, go to IDLE.
    - A transfer in the same cycle as the expiry wins: no error.
  - COMMIT_H / COMMIT_L / COMMIT_B: in_ready=0, for exactly one cycle.
    - loadh and/or loadl are 1: COMMIT_H asserts loadh, COMMIT_L asserts loadl, COMMIT_B asserts both in the same cycle.
    - done=1.
    - word_count increments, wrapping from 2^CW-1 to 0.
    - Next state is IDLE.
- Latency and throughput:
  - Load pulses are asserted the cycle after the final byte transfer.
  - Single-byte transactions sustain one per 2 cycles.
  - BOTH transactions sustain one per 3 cycles.
- inh and inl hold their last value when not loading. The bus in the untouched half is don't-care to the register, but must not change.
- Simultaneous loadh and loadl occur only in COMMIT_B. A BOTH word is never split into separate pulses, except as described under Optional Feature.
- in_data and in_mode are ignored whenever in_ready=0.

Optional Feature:
- Macro: BYTE_PAIR_PARTIAL_COMMIT_EN.
- Defined: on HAVE_HI timeout, go to COMMIT_H with inh<=hi_buf. This:
  - emits loadh and done,
  - increments word_count,
  - still pulses timeout_err, in the same cycle as loadh.
- Undefined: the held byte is discarded as described in Behaviour.

Decomposition:
- Shared package byte_pair_pkg holds:
  - typedef enum logic[1:0] mode_t {HI_ONLY, LO_ONLY, BOTH, RSVD},
  - typedef enum state_t for the five states,
  - default N and TIMEOUT localparams.
- One natural sub-module, bp_timeout_timer:
  - inputs: clear_n, clk, clr, en,
  - output: expire pulse,
  - parameter TIMEOUT.
- The top level contains the FSM, hold buffers and counter.

Test Plan:
- Reset: hold clear_n=0 mid-HAVE_HI with hi_buf=0xAB, then release -> all outputs 0, state IDLE, no loadh/loadl ever pulses for 0xAB.
- HI_ONLY: send in_data=0x5A, mode 0 -> next cycle loadh=1, loadl=0, inh=0x5A, done=1, word_count=1, in_ready=0 for that one cycle.
- BOTH: send 0x12 (mode 2), then 0x34 one cycle later -> one cycle with loadh=loadl=1, inh=0x12, inl=0x34, done=1. The target register reads 0x1234.
- Back-to-back with valid held high: LO_ONLY 0x01, then 0x02, then 0x03 -> loadl pulses every 2 cycles with inl=0x01/0x02/0x03, and word_count steps 1, 2, 3.
- Timeout (TIMEOUT=4): send 0xCC in mode 2, then idle 4 cycles:
  - macro undefined -> timeout_err pulses once, no loads, word_count unchanged;
  - macro defined -> loadh=1 with inh=0xCC, plus timeout_err and done.
- Wrap and reserved mode (CW=2): commit 4 LO_ONLY words -> word_count goes 3 to 0. Then send mode 3 -> byte accepted, no pulse, count stays 0.
